vape_or_reader: RTL and testbench

Reads the protected output region (OR) back out of memory after an attested execution and streams it, one 16-bit word per handshake, to the attestation/report path. It sits downstream of the output-protection monitor and consumes that monitor's `exec` flag. A read completes with `ok` only if `exec` stays high from `start` through the last word. If `exec` drops at any point, the stream is aborted and flagged as tampered.

---
 rtl/vape_or_reader.sv | 135 +++++++++++++
 tb/tb_vape_or_reader.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vape_or_reader.sv
// vape_or_reader: streams the protected output region back out of memory.
// Aborts with TAMPER if exec drops or the core returns to the reset handler.
module vape_or_reader #(
    parameter logic [15:0] RESET_HANDLER = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] pc,
    input  logic        start,
    input  logic [15:0] OR_min,
    input  logic [15:0] OR_max,
    input  logic        exec,
    output logic        mem_en,
    output logic [15:0] mem_addr,
    input  logic [15:0] mem_rdata,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        busy,
    output logic        done,
    output logic        ok,
    output logic [1:0]  err_code
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CAPTURE,
        S_SEND,
        S_DONE
    } state_t;

    localparam logic [1:0] ERR_NONE   = 2'd0;
    localparam logic [1:0] ERR_RANGE  = 2'd1;
    localparam logic [1:0] ERR_NOEXEC = 2'd2;
    localparam logic [1:0] ERR_TAMPER = 2'd3;

    state_t      state_q, state_d;
    logic [15:0] cur_q;
    logic [15:0] end_q;
    logic        active;
    logic        tamper;
    logic        range_bad;
    logic        at_end;

    assign active    = (state_q == S_READ) || (state_q == S_CAPTURE)
                    || (state_q == S_SEND);
    assign tamper    = active && (!exec || (pc == RESET_HANDLER));
    assign range_bad = (OR_min >= OR_max) || OR_min[0] || OR_max[0];
    assign at_end    = (cur_q == end_q);

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state and combinational outputs; tamper overrides every transition
    always_comb begin
        state_d  = state_q;
        mem_en   = 1'b0;
        mem_addr = 16'h0000;
        busy     = active;
        done     = 1'b0;
        out_last = out_valid && at_end;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (range_bad)  state_d = S_DONE;
                    else if (!exec) state_d = S_DONE;
                    else            state_d = S_READ;
                end
            end
            S_READ: begin
                mem_en   = 1'b1;
                mem_addr = cur_q;
                state_d  = S_CAPTURE;
            end
            S_CAPTURE: state_d = S_SEND;
            S_SEND: begin
                if (out_ready) state_d = at_end ? S_DONE : S_READ;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (tamper) state_d = S_DONE;
    end

    // Datapath: address walk, output word register and result flags
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_q     <= 16'h0000;
            end_q     <= 16'h0000;
            out_data  <= 16'h0000;
            out_valid <= 1'b0;
            ok        <= 1'b0;
            err_code  <= ERR_NONE;
        end else if (tamper) begin
            out_valid <= 1'b0;
            ok        <= 1'b0;
            err_code  <= ERR_TAMPER;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        cur_q <= OR_min;
                        end_q <= OR_max;
                        ok    <= 1'b0;
                        if (range_bad)  err_code <= ERR_RANGE;
                        else if (!exec) err_code <= ERR_NOEXEC;
                        else            err_code <= ERR_NONE;
                    end
                end
                S_CAPTURE: begin
                    out_data  <= mem_rdata;
                    out_valid <= 1'b1;
                end
                S_SEND: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (at_end) ok    <= 1'b1;
                        else        cur_q <= cur_q + 16'd2;
                    end
                end
                S_DONE:  out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vape_or_reader.sv
// tb_vape_or_reader: directed self-checking bench for vape_or_reader.
// Memory is modelled in the bench; expected values are hand-computed.
module tb_vape_or_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] pc;
    logic        start;
    logic [15:0] OR_min;
    logic [15:0] OR_max;
    logic        exec;
    logic        mem_en;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;
    logic        done;
    logic        ok;
    logic [1:0]  err_code;

    int n_cmp = 0;
    int n_bad = 0;
    int mem_cnt = 0;
    int cnt0;

    logic [15:0] mem [0:511];

    vape_or_reader dut (
        .clk(clk), .reset(reset), .pc(pc), .start(start),
        .OR_min(OR_min), .OR_max(OR_max), .exec(exec),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .done(done), .ok(ok),
        .err_code(err_code)
    );

    always #5 clk = ~clk;

    // Memory model: read registered mid-cycle, data ready before capture
    always @(negedge clk) begin
        if (mem_en) begin
            mem_rdata <= mem[mem_addr[9:1]];
            mem_cnt   <= mem_cnt + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_run(input logic [15:0] lo, input logic [15:0] hi);
        OR_min = lo;
        OR_max = hi;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    // One word with out_ready high: READ, CAPTURE, SEND
    task automatic word(input logic [15:0] addr, input logic [15:0] data,
                        input logic last);
        chk("read_en", {15'd0, mem_en}, 16'd1);
        chk("read_addr", mem_addr, addr);
        tick();
        tick();
        chk("send_valid", {15'd0, out_valid}, 16'd1);
        chk("send_data", out_data, data);
        chk("send_last", {15'd0, out_last}, {15'd0, last});
        tick();
    endtask

    task automatic chk_end(input string tag, input logic okv,
                           input logic [1:0] err);
        chk({tag, "_done"}, {15'd0, done}, 16'd1);
        chk({tag, "_ok"}, {15'd0, ok}, {15'd0, okv});
        chk({tag, "_err"}, {14'd0, err_code}, {14'd0, err});
        chk({tag, "_valid"}, {15'd0, out_valid}, 16'd0);
        chk({tag, "_busy"}, {15'd0, busy}, 16'd0);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 16'h0000;
        mem[9'h100] = 16'h00A1;
        mem[9'h101] = 16'h00A2;
        mem[9'h102] = 16'h00A3;
        mem[9'h103] = 16'h00A4;
        mem[9'h180] = 16'h00EE;
        mem_rdata = 16'h0000;
        reset = 1'b1; pc = 16'h4000; start = 1'b0;
        OR_min = 16'h0200; OR_max = 16'h0206;
        exec = 1'b1; out_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_mem_en", {15'd0, mem_en}, 16'd0);
        chk("rst_mem_addr", mem_addr, 16'd0);
        chk("rst_out_data", out_data, 16'd0);
        chk("rst_out_valid", {15'd0, out_valid}, 16'd0);
        chk("rst_out_last", {15'd0, out_last}, 16'd0);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_done", {15'd0, done}, 16'd0);
        chk("rst_ok", {15'd0, ok}, 16'd0);
        chk("rst_err", {14'd0, err_code}, 16'd0);

        // Clean run
        cnt0 = mem_cnt;
        start_run(16'h0200, 16'h0206);
        chk("clean_busy", {15'd0, busy}, 16'd1);
        word(16'h0200, 16'h00A1, 1'b0);
        word(16'h0202, 16'h00A2, 1'b0);
        word(16'h0204, 16'h00A3, 1'b0);
        word(16'h0206, 16'h00A4, 1'b1);
        chk_end("clean", 1'b1, 2'd0);
        tick();
        chk("clean_done_pulse", {15'd0, done}, 16'd0);
        chk("clean_ok_held", {15'd0, ok}, 16'd1);
        chk("clean_reads", mem_cnt[15:0] - cnt0[15:0], 16'd4);

        // Backpressure on word 2
        cnt0 = mem_cnt;
        start_run(16'h0200, 16'h0206);
        chk("bp_ok_cleared", {15'd0, ok}, 16'd0);
        word(16'h0200, 16'h00A1, 1'b0);
        out_ready = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", {15'd0, out_valid}, 16'd1);
            chk("bp_data", out_data, 16'h00A2);
            chk("bp_no_mem_en", {15'd0, mem_en}, 16'd0);
            tick();
        end
        chk("bp_valid_end", {15'd0, out_valid}, 16'd1);
        out_ready = 1'b1;
        tick();
        word(16'h0204, 16'h00A3, 1'b0);
        word(16'h0206, 16'h00A4, 1'b1);
        chk_end("bp", 1'b1, 2'd0);
        tick();
        chk("bp_reads", mem_cnt[15:0] - cnt0[15:0], 16'd4);

        // Range errors
        cnt0 = mem_cnt;
        start_run(16'h0300, 16'h0300);
        chk_end("range_eq", 1'b0, 2'd1);
        chk("range_eq_mem_en", {15'd0, mem_en}, 16'd0);
        tick();
        chk("range_eq_done_pulse", {15'd0, done}, 16'd0);
        chk("range_eq_err_held", {14'd0, err_code}, 16'd1);
        start_run(16'h0201, 16'h0206);
        chk_end("range_odd", 1'b0, 2'd1);
        tick();
        chk("range_reads", mem_cnt[15:0] - cnt0[15:0], 16'd0);

        // NOEXEC
        exec = 1'b0;
        start_run(16'h0200, 16'h0206);
        chk_end("noexec", 1'b0, 2'd2);
        chk("noexec_mem_en", {15'd0, mem_en}, 16'd0);
        tick();
        exec = 1'b1;
        chk("noexec_reads", mem_cnt[15:0] - cnt0[15:0], 16'd0);

        // Tamper by exec drop in SEND of word 2, coinciding with out_ready
        cnt0 = mem_cnt;
        start_run(16'h0200, 16'h0206);
        word(16'h0200, 16'h00A1, 1'b0);
        tick();
        tick();
        chk("tx_send_data", out_data, 16'h00A2);
        exec = 1'b0;
        tick();
        exec = 1'b1;
        chk_end("tamper_exec", 1'b0, 2'd3);
        tick();
        tick();
        chk("tx_reads", mem_cnt[15:0] - cnt0[15:0], 16'd2);
        chk("tx_idle_busy", {15'd0, busy}, 16'd0);

        // Tamper by pc hitting the reset handler
        cnt0 = mem_cnt;
        start_run(16'h0200, 16'h0206);
        word(16'h0200, 16'h00A1, 1'b0);
        tick();
        tick();
        pc = 16'h0000;
        tick();
        pc = 16'h4000;
        chk_end("tamper_pc", 1'b0, 2'd3);
        tick();
        tick();
        chk("tp_reads", mem_cnt[15:0] - cnt0[15:0], 16'd2);

        // Reset during CAPTURE
        start_run(16'h0200, 16'h0206);
        tick();
        chk("rc_in_capture", {15'd0, busy}, 16'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rc_busy", {15'd0, busy}, 16'd0);
        chk("rc_done", {15'd0, done}, 16'd0);
        chk("rc_valid", {15'd0, out_valid}, 16'd0);
        chk("rc_data", out_data, 16'd0);
        chk("rc_err", {14'd0, err_code}, 16'd0);
        chk("rc_mem_en", {15'd0, mem_en}, 16'd0);
        tick();
        chk("rc_no_done", {15'd0, done}, 16'd0);

        // Start while busy with a changed range is ignored
        start_run(16'h0200, 16'h0206);
        start  = 1'b1;
        OR_min = 16'h0300;
        OR_max = 16'h0310;
        chk("sb_read_addr", mem_addr, 16'h0200);
        tick();
        tick();
        start = 1'b0;
        chk("sb_data1", out_data, 16'h00A1);
        tick();
        word(16'h0202, 16'h00A2, 1'b0);
        word(16'h0204, 16'h00A3, 1'b0);
        word(16'h0206, 16'h00A4, 1'b1);
        chk_end("sb", 1'b1, 2'd0);
        tick();
        chk("sb_idle", {15'd0, busy}, 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
